// File: rtl/stage_skid_buffer.sv
// rtl/stage_skid_buffer.sv - two-entry skid buffer with flush and saturating stall counter
module stage_skid_buffer #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic [TAG_W-1:0]  i_in_tag,
  input  logic              i_flush,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [TAG_W-1:0]  o_out_tag,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam int WORD_W = DATA_W + TAG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WORD_W-1:0]  r_main;
  logic [WORD_W-1:0]  r_skid;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic [WORD_W-1:0]  w_in_word;
  logic               w_in_xfer;
  logic               w_out_xfer;

  assign w_in_word  = {i_in_data, i_in_tag};
  assign w_in_xfer  = i_in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & i_out_ready;

  // Occupancy FSM; the handshake flags are registered alongside the state so
  // neither depends combinationally on the downstream ready.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (i_flush) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_main      <= w_in_word;
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= w_in_word;
          end else if (w_in_xfer) begin
            r_skid     <= w_in_word;
            r_state    <= S_FULL;
            r_in_ready <= 1'b0;
          end else if (w_out_xfer) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (i_out_ready) begin
            r_main     <= r_skid;
            r_state    <= S_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_main      <= '0;
          r_skid      <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Debug counter of cycles where a word waits on downstream; saturates, reset-only clear.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !i_out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  // Bubbles are presented as all-zero so a stale main word never leaks out.
  assign o_out_data  = r_out_valid ? r_main[WORD_W-1:TAG_W] : '0;
  assign o_out_tag   = r_out_valid ? r_main[TAG_W-1:0]      : '0;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_stage_skid_buffer.sv
// tb/tb_stage_skid_buffer.sv - directed vector bench for stage_skid_buffer
module tb_stage_skid_buffer;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [CNT_W-1:0]  stall_cnt;

  int errors;
  int checks;

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t;
    logic              ordy;
    logic              fl;
    logic              e_ov;
    logic [DATA_W-1:0] e_d;
    logic [TAG_W-1:0]  e_t;
    logic              e_ir;
  } vec_t;

  vec_t vecs[$];

  stage_skid_buffer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_in_tag    (in_tag),
    .i_flush     (flush),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_tag   (out_tag),
    .o_stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_tag    = t;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic add(input logic iv, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                     input logic ordy, input logic fl, input logic e_ov,
                     input logic [DATA_W-1:0] e_d, input logic [TAG_W-1:0] e_t, input logic e_ir);
    vec_t v;
    v.iv = iv; v.d = d; v.t = t; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_d = e_d; v.e_t = e_t; v.e_ir = e_ir;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // streaming, one word per cycle, one-cycle latency
    add(1, 16'h1111, 4'h1, 1, 0,  1, 16'h1111, 4'h1, 1);
    add(1, 16'h2222, 4'h2, 1, 0,  1, 16'h2222, 4'h2, 1);
    add(1, 16'h3333, 4'h3, 1, 0,  1, 16'h3333, 4'h3, 1);
    add(0, 16'h0000, 4'h0, 1, 0,  0, 16'h0000, 4'h0, 1);
    // stall fill and drain
    add(1, 16'hAAAA, 4'hA, 0, 0,  1, 16'hAAAA, 4'hA, 1);
    add(1, 16'hBBBB, 4'hB, 0, 0,  1, 16'hAAAA, 4'hA, 0);
    add(1, 16'hCCCC, 4'hC, 0, 0,  1, 16'hAAAA, 4'hA, 0);
    add(0, 16'h0000, 4'h0, 1, 0,  1, 16'hBBBB, 4'hB, 1);
    add(0, 16'h0000, 4'h0, 1, 0,  0, 16'h0000, 4'h0, 1);
    // flush from FULL with a word offered on the same cycle
    add(1, 16'hAAAA, 4'hA, 0, 0,  1, 16'hAAAA, 4'hA, 1);
    add(1, 16'hBBBB, 4'hB, 0, 0,  1, 16'hAAAA, 4'hA, 0);
    add(1, 16'hCCCC, 4'hC, 0, 1,  0, 16'h0000, 4'h0, 1);
    add(0, 16'h0000, 4'h0, 1, 0,  0, 16'h0000, 4'h0, 1);
    // flush from ONE while an input transfer would otherwise happen
    add(1, 16'hDDDD, 4'hD, 0, 0,  1, 16'hDDDD, 4'hD, 1);
    add(1, 16'hEEEE, 4'hE, 0, 1,  0, 16'h0000, 4'h0, 1);
    add(0, 16'h0000, 4'h0, 1, 0,  0, 16'h0000, 4'h0, 1);

    // reset held with random inputs
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_stall_cnt", stall_cnt, 0);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);

    // table run
    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].t, vecs[i].ordy, vecs[i].fl);
      step();
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_d);
      check($sformatf("v%0d_out_tag", i), out_tag, vecs[i].e_t);
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
    end
    // stalled edges in the table: v5, v6, v10, v11, v14
    check("table_stall_cnt", stall_cnt, 5);

    // stall counter saturation
    do_reset();
    drive(1'b1, 16'h7777, 4'h7, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("sat_start", stall_cnt, 0);
    for (int m = 1; m <= 20; m++) begin
      step();
      check($sformatf("sat_m%0d", m), stall_cnt, (m > 15) ? 15 : m);
      check($sformatf("sat_hold_m%0d", m), out_data, 16'h7777);
    end

    // async reset in the middle of a stall
    do_reset();
    drive(1'b1, 16'hAAAA, 4'hA, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'hBBBB, 4'hB, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("ar_full_in_ready", in_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_stall_cnt", stall_cnt, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_out_data", out_data, 0);
    #1;
    rst = 1'b1;
    step();
    drive(1'b1, 16'h5555, 4'h5, 1'b1, 1'b0);
    #1;
    check("ar_no_passthru", out_valid, 0);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("ar_5555_valid", out_valid, 1);
    check("ar_5555_data", out_data, 16'h5555);
    check("ar_5555_tag", out_tag, 4'h5);
    step();
    check("ar_drained", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stage_skid_buffer.md
# stage_skid_buffer

Two-entry skid buffer for the receiving end of a CPU pipeline-stage boundary. It accepts a 16-bit word plus a 4-bit register tag from an upstream stage with a valid/ready handshake and presents it to the downstream stage. Downstream stalls never lose a word, and `in_ready` is fully registered. It sits between adjacent pipeline stages and adds flush support and a saturating stall counter for debug.

## Interface
- `DATA_W`, default 16: payload width.
- `TAG_W`, default 4: register-tag width.
- `CNT_W`, default 8: stall-counter width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  buffer can accept; registered.
- `in_data`  in  DATA_W  upstream payload.
- `in_tag`  in  TAG_W  upstream tag.
- `flush`  in  1  synchronous discard of all held words.
- `out_valid`  out  1  word presented downstream.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  payload; 0 when `out_valid`=0.
- `out_tag`  out  TAG_W  tag; 0 when `out_valid`=0.
- `stall_cnt`  out  CNT_W  saturating count of stalled cycles.

## Operation
- Storage: main register (drives outputs) and skid register.
- State: EMPTY (0 words), ONE (main valid), FULL (main and skid valid).
- Transfers:
  - Input transfer occurs when `in_valid`=1 and `in_ready`=1.
  - Output transfer occurs when `out_valid`=1 and `out_ready`=1.
- Transitions:
  - EMPTY
    - input transfer: main<=in, go to ONE.
    - otherwise stay.
  - ONE
    - input and output transfer together: main<=in, stay ONE.
    - input transfer only: skid<=in, go to FULL.
    - output transfer only: go to EMPTY.
    - neither: stay.
  - FULL
    - `out_ready`=1: main<=skid, go to ONE.
    - otherwise stay.
    - Inputs are ignored, since `in_ready`=0.
- Output flags: `in_ready` = (state != FULL); `out_valid` = (state != EMPTY).
- Bubble masking: `out_data` and `out_tag` are forced to 0 whenever `out_valid`=0, so the bubble equals all-zero.
- Ordering: words leave in arrival order; the skid word is never presented before the main word.
- `flush`: highest priority. On the next edge the state goes to EMPTY, both registers clear to 0, and any same-cycle input transfer is dropped. `stall_cnt` is unaffected.
- `stall_cnt`
  - Increments by 1 each edge where `out_valid`=1 and `out_ready`=0.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - Cleared only by reset.
- Reset (async, any time, including mid-transfer)
  - State goes to EMPTY; main, skid and `stall_cnt` go to 0.
  - Outputs during reset: `out_valid`=0, `out_data`=0, `out_tag`=0, `in_ready`=1, `stall_cnt`=0.
  - `in_ready` is 1 as soon as reset asserts.
- Illegal state encoding recovers to EMPTY.

## Timing
- Latency: a word accepted at edge N appears on `out_*` after edge N, one cycle. Zero-cycle combinational pass-through is not permitted.
- Throughput: one word per cycle when `out_ready` is held high.
- `in_ready` falls the cycle after the second word is buffered with downstream stalled. It rises the cycle after the downstream transfer that empties skid.
- Upstream may drop `in_valid` at any time. Downstream may drop `out_ready` at any time.
- No combinational path from `out_ready` to `in_ready`. Outputs depend only on registered state.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_tag` are held stable.

## Test plan
- Reset
  - Stimulus: hold `rst`=0 with random inputs, then release.
  - Required: `out_valid`=0, `out_data`=0, `in_ready`=1, `stall_cnt`=0 throughout reset; state EMPTY after release.
- Streaming
  - Stimulus: `out_ready`=1; send 0x1111/tag 1, 0x2222/tag 2, 0x3333/tag 3 on consecutive cycles.
  - Required: each appears exactly one cycle later, in order, with `in_ready` constantly 1.
- Stall fill
  - Stimulus: `out_ready`=0; send 0xAAAA then 0xBBBB.
  - Required: `in_ready`=0 after the second word; `out_data` holds 0xAAAA.
  - Stimulus: raise `out_ready`.
  - Required: 0xAAAA then 0xBBBB are transferred; `in_ready` back to 1.
- Stall counter saturation
  - Stimulus: `CNT_W`=4; hold one word with `out_ready`=0 for 20 cycles.
  - Required: `stall_cnt` reaches 15 and stays 15.
- Flush
  - Stimulus: FULL with 0xAAAA/0xBBBB; assert `flush` together with `in_valid` carrying 0xCCCC.
  - Required: next cycle EMPTY, `out_data`=0; 0xCCCC never appears.
- Async reset mid-stall
  - Stimulus: in FULL, pulse `rst` low between clock edges.
  - Required: `out_valid` and `stall_cnt` clear immediately without waiting for an edge; after release, a new word 0x5555 passes through with 1-cycle latency.
